// File: rtl/pse_pkg.sv
// Shared types for param_shift_engine: 3-bit op encoding (same as the legacy
// 8-mode shift register) and the two-state sequencer FSM.
package pse_pkg;

    localparam logic [2:0] OPC_CLR  = 3'd0;
    localparam logic [2:0] OPC_LOAD = 3'd1;
    localparam logic [2:0] OPC_LSR  = 3'd2;
    localparam logic [2:0] OPC_LSL  = 3'd3;
    localparam logic [2:0] OPC_ASR  = 3'd4;
    localparam logic [2:0] OPC_SIN  = 3'd5;
    localparam logic [2:0] OPC_ROR  = 3'd6;
    localparam logic [2:0] OPC_ROL  = 3'd7;

    typedef enum logic [2:0] {
        OP_CLR  = OPC_CLR,
        OP_LOAD = OPC_LOAD,
        OP_LSR  = OPC_LSR,
        OP_LSL  = OPC_LSL,
        OP_ASR  = OPC_ASR,
        OP_SIN  = OPC_SIN,
        OP_ROR  = OPC_ROR,
        OP_ROL  = OPC_ROL
    } op_e;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

endpackage

// File: rtl/param_shift_engine_if.sv
// Command handshake bundle for param_shift_engine: valid/ready plus op,
// shift amount and parallel load data.
interface param_shift_engine_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AMT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] load_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_amt,
        output load_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_amt,
        input  load_data,
        output cmd_ready
    );
endinterface

// File: rtl/pse_step.sv
// Combinational single-bit step of the shift engine: next register value and
// the bit that leaves the register. CLR/LOAD pass the value through untouched.
module pse_step
    import pse_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  op_e              op,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_d,
    output logic             shifted_out
);

    always_comb begin
        next_d      = d;
        shifted_out = 1'b0;
        case (op)
            OP_LSR: begin
                next_d      = {1'b0, d[WIDTH-1:1]};
                shifted_out = d[0];
            end
            OP_LSL: begin
                next_d      = {d[WIDTH-2:0], 1'b0};
                shifted_out = d[WIDTH-1];
            end
            OP_ASR: begin
                next_d      = {d[WIDTH-1], d[WIDTH-1:1]};
                shifted_out = d[0];
            end
            OP_SIN: begin
                next_d      = {ser_in, d[WIDTH-1:1]};
                shifted_out = d[0];
            end
            OP_ROR: begin
                next_d      = {d[0], d[WIDTH-1:1]};
                shifted_out = d[0];
            end
            OP_ROL: begin
                next_d      = {d[WIDTH-2:0], d[WIDTH-1]};
                shifted_out = d[WIDTH-1];
            end
            default: begin
                next_d      = d;
                shifted_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/param_shift_engine.sv
// Parametrised multi-step shift engine: one bit per cycle under an IDLE/SHIFT
// FSM with valid/ready command handshake. Optional abort via PSE_ABORT_EN.
module param_shift_engine
    import pse_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    param_shift_engine_if.slave  bus,
    input  logic                 ser_in,
    output logic [WIDTH-1:0]     dout,
    output logic                 ser_out,
    output logic                 busy,
    output logic                 done
`ifdef PSE_ABORT_EN
    ,
    input  logic                 abort,
    output logic                 aborted
`endif
);

    state_e           state;
    op_e              op_q;
    logic [AMT_W-1:0] cnt;
    op_e              cur_op;
    logic [WIDTH-1:0] next_d;
    logic             shifted_out;

    assign busy          = (state == SHIFT);
    assign bus.cmd_ready = (state == IDLE);

    // In IDLE the first step uses the incoming op directly; later steps use the latched op.
    assign cur_op = busy ? op_q : op_e'(bus.cmd_op);

    pse_step #(.WIDTH(WIDTH)) u_step (
        .d           (dout),
        .op          (cur_op),
        .ser_in      (ser_in),
        .next_d      (next_d),
        .shifted_out (shifted_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_CLR;
            cnt     <= '0;
            dout    <= '0;
            ser_out <= 1'b0;
            done    <= 1'b0;
`ifdef PSE_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PSE_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q <= cur_op;
                        case (cur_op)
                            OP_CLR: begin
                                dout    <= '0;
                                ser_out <= 1'b0;
                                done    <= 1'b1;
                            end
                            OP_LOAD: begin
                                dout    <= bus.load_data;
                                ser_out <= 1'b0;
                                done    <= 1'b1;
                            end
                            default: begin
                                if (bus.cmd_amt == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    dout    <= next_d;
                                    ser_out <= shifted_out;
                                    cnt     <= bus.cmd_amt - 1'b1;
                                    if (bus.cmd_amt > AMT_W'(1))
                                        state <= SHIFT;
                                    else
                                        done <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
`ifdef PSE_ABORT_EN
                    if (abort) begin
                        cnt     <= '0;
                        state   <= IDLE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else
`endif
                    begin
                        dout    <= next_d;
                        ser_out <= shifted_out;
                        cnt     <= cnt - 1'b1;
                        if (cnt == AMT_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_shift_engine.sv
// Directed self-checking bench for param_shift_engine (WIDTH=8); covers the
// abort path when PSE_ABORT_EN is defined.
module tb_param_shift_engine;
    import pse_pkg::*;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             ser_in;
    logic [WIDTH-1:0] dout;
    logic             ser_out;
    logic             busy;
    logic             done;
`ifdef PSE_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    param_shift_engine_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    param_shift_engine #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .ser_in  (ser_in),
        .dout    (dout),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
`ifdef PSE_ABORT_EN
        ,
        .abort   (abort),
        .aborted (aborted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a command for exactly one edge (edge T), then sample #1 later.
    task automatic issue(input logic [2:0] op, input logic [AMT_W-1:0] amt,
                         input logic [WIDTH-1:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_amt   = amt;
        bus.load_data = data;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total_cnt++;
        if (dout !== 8'h00) $display("FAIL reset_dout actual=%h required=00", dout); else pass_cnt++;
        total_cnt++;
        if ({busy, done, ser_out} !== 3'b000) $display("FAIL reset_flags actual=%b required=000", {busy, done, ser_out}); else pass_cnt++;
        total_cnt++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready actual=%b required=1", bus.cmd_ready); else pass_cnt++;
        #9 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        issue(OPC_LOAD, 4'd0, 8'hA5);
        total_cnt++;
        if (dout !== 8'hA5) $display("FAIL load_dout actual=%h required=a5", dout); else pass_cnt++;
        total_cnt++;
        if ({done, bus.cmd_ready, busy} !== 3'b110) $display("FAIL load_done actual=%b required=110", {done, bus.cmd_ready, busy}); else pass_cnt++;
        tick();
        total_cnt++;
        if ({done, bus.cmd_ready} !== 2'b01) $display("FAIL load_done_clear actual=%b required=01", {done, bus.cmd_ready}); else pass_cnt++;
    endtask

    task automatic test_asr();
        logic [WIDTH-1:0] exp_d [3];
        exp_d[0] = 8'hCB; exp_d[1] = 8'hE5; exp_d[2] = 8'hF2;
        issue(OPC_LOAD, 4'd0, 8'h96);
        issue(OPC_ASR, 4'd3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            total_cnt++;
            if (dout !== exp_d[i]) $display("FAIL asr_step%0d actual=%h required=%h", i, dout, exp_d[i]); else pass_cnt++;
            total_cnt++;
            if ({busy, done} !== ((i < 2) ? 2'b10 : 2'b01))
                $display("FAIL asr_status%0d actual=%b required=%b", i, {busy, done}, (i < 2) ? 2'b10 : 2'b01);
            else pass_cnt++;
        end
        total_cnt++;
        if (ser_out !== 1'b1) $display("FAIL asr_ser_out actual=%b required=1", ser_out); else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL asr_done_clear actual=%b required=0", done); else pass_cnt++;
    endtask

    task automatic test_rol_wrap();
        int early_done = 0;
        issue(OPC_LOAD, 4'd0, 8'h81);
        issue(OPC_ROL, 4'd9, 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (done !== 1'b0 || busy !== 1'b1) early_done++;
            tick();
        end
        total_cnt++;
        if (early_done != 0) $display("FAIL rol_busy_window actual=%0d bad cycles required=0", early_done); else pass_cnt++;
        total_cnt++;
        if ({dout, ser_out, done, busy} !== {8'h03, 1'b1, 1'b1, 1'b0})
            $display("FAIL rol_final actual=%h/%b/%b/%b required=03/1/1/0", dout, ser_out, done, busy);
        else pass_cnt++;
        issue(OPC_LSL, 4'd0, 8'hFF);
        total_cnt++;
        if ({dout, ser_out, done, busy} !== {8'h03, 1'b1, 1'b1, 1'b0})
            $display("FAIL lsl_zero actual=%h/%b/%b/%b required=03/1/1/0", dout, ser_out, done, busy);
        else pass_cnt++;
    endtask

    task automatic test_sin();
        logic [3:0]       bits;
        logic [WIDTH-1:0] exp_d [4];
        bits = 4'b1011;
        exp_d[0] = 8'h80; exp_d[1] = 8'h40; exp_d[2] = 8'hA0; exp_d[3] = 8'hD0;
        issue(OPC_CLR, 4'd0, 8'h00);
        total_cnt++;
        if ({dout, done} !== {8'h00, 1'b1}) $display("FAIL clr actual=%h/%b required=00/1", dout, done); else pass_cnt++;
        ser_in = bits[3];
        issue(OPC_SIN, 4'd4, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                ser_in = bits[3 - i];
                tick();
            end
            total_cnt++;
            if (dout !== exp_d[i]) $display("FAIL sin_step%0d actual=%h required=%h", i, dout, exp_d[i]); else pass_cnt++;
        end
        total_cnt++;
        if ({ser_out, done} !== 2'b01) $display("FAIL sin_final actual=%b required=01", {ser_out, done}); else pass_cnt++;
        ser_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue(OPC_LOAD, 4'd0, 8'hF0);
        issue(OPC_LSR, 4'd5, 8'h00);
        total_cnt++;
        if ({dout, bus.cmd_ready} !== {8'h78, 1'b0}) $display("FAIL lsr_first actual=%h/%b required=78/0", dout, bus.cmd_ready); else pass_cnt++;
        issue(OPC_LOAD, 4'd0, 8'hFF);
        total_cnt++;
        if (dout !== 8'h3C) $display("FAIL busy_ignore actual=%h required=3c", dout); else pass_cnt++;
        tick();
        tick();
        tick();
        total_cnt++;
        if ({dout, ser_out, done, bus.cmd_ready} !== {8'h07, 1'b1, 1'b1, 1'b1})
            $display("FAIL lsr_final actual=%h/%b/%b/%b required=07/1/1/1", dout, ser_out, done, bus.cmd_ready);
        else pass_cnt++;
        issue(OPC_LOAD, 4'd0, 8'h11);
        total_cnt++;
        if ({dout, done} !== {8'h11, 1'b1}) $display("FAIL b2b_load actual=%h/%b required=11/1", dout, done); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        issue(OPC_LOAD, 4'd0, 8'h5A);
        issue(OPC_ROR, 4'd6, 8'h00);
        tick();
        total_cnt++;
        if ({dout, busy} !== {8'h96, 1'b1}) $display("FAIL ror_pre_reset actual=%h/%b required=96/1", dout, busy); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({dout, busy, done, bus.cmd_ready} !== {8'h00, 1'b0, 1'b0, 1'b1})
            $display("FAIL mid_reset actual=%h/%b/%b/%b required=00/0/0/1", dout, busy, done, bus.cmd_ready);
        else pass_cnt++;
        tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done !== 1'b0 || dout !== 8'h00) seen_done++;
        end
        total_cnt++;
        if (seen_done != 0) $display("FAIL reset_no_done actual=%0d bad cycles required=0", seen_done); else pass_cnt++;
    endtask

`ifdef PSE_ABORT_EN
    task automatic test_abort();
        issue(OPC_LOAD, 4'd0, 8'h5A);
        abort = 1'b1;
        tick();
        total_cnt++;
        if ({dout, done, aborted} !== {8'h5A, 1'b0, 1'b0}) $display("FAIL abort_idle actual=%h/%b/%b required=5a/0/0", dout, done, aborted); else pass_cnt++;
        abort = 1'b0;
        issue(OPC_ROR, 4'd6, 8'h00);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if ({dout, done, aborted, busy} !== {8'h96, 1'b1, 1'b1, 1'b0})
            $display("FAIL abort_hold actual=%h/%b/%b/%b required=96/1/1/0", dout, done, aborted, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({dout, done, aborted} !== {8'h96, 1'b0, 1'b0}) $display("FAIL abort_clear actual=%h/%b/%b required=96/0/0", dout, done, aborted); else pass_cnt++;
    endtask
`endif

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_amt   = '0;
        bus.load_data = '0;
        ser_in        = 1'b0;
`ifdef PSE_ABORT_EN
        abort         = 1'b0;
`endif
        test_reset();
        test_load();
        test_asr();
        test_rol_wrap();
        test_sin();
        test_back_to_back();
        test_reset_mid();
`ifdef PSE_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
